pwm_timebase: RTL

Parametrised PWM timebase for the PWM controller. Divides clk_i by a programmable prescale (divide ratio prescale+1) and drives a period counter. The counter runs edge-aligned (sawtooth, 0..top) or center-aligned (triangle, 0..top..0). Prescale, top and mode are double-buffered and take effect only at period boundaries. Channel comparators consume counter_o, dir_o and period_o.

---
 rtl/pwm_timebase.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaled edge- or center-aligned period counter with
// double-buffered prescale/top/mode that take effect at period boundaries.
module pwm_timebase #(
   parameter int unsigned      CNT_W   = 12,
   parameter int unsigned      PRE_W   = 8,
   parameter logic [CNT_W-1:0] TOP_RST = {CNT_W{1'b1}}
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             enable_i,
   input  logic             clear_i,
   input  logic [PRE_W-1:0] prescale_i,
   input  logic [CNT_W-1:0] top_i,
   input  logic             center_i,
   output logic [CNT_W-1:0] counter_o,
   output logic             dir_o,
   output logic             tick_o,
   output logic             period_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             tick_q, tick_d;
   logic             period_q, period_d;

   logic [PRE_W-1:0] pre_sh_q, pre_sh_d;
   logic [CNT_W-1:0] top_sh_q, top_sh_d;
   logic             ctr_sh_q, ctr_sh_d;
   logic             load_sh;

   always_comb begin
      pre_d    = pre_q;
      cnt_d    = cnt_q;
      dir_d    = dir_q;
      tick_d   = 1'b0;
      period_d = 1'b0;
      load_sh  = 1'b0;

      if (clear_i) begin
         pre_d   = '0;
         cnt_d   = '0;
         dir_d   = 1'b0;
         load_sh = 1'b1;
      end else if (!enable_i) begin
         pre_d   = '0;
         load_sh = 1'b1;
      end else if (pre_q == pre_sh_q) begin
         pre_d  = '0;
         tick_d = 1'b1;
         if (top_sh_q == '0) begin
            // Degenerate period: every tick is a boundary.
            cnt_d    = '0;
            dir_d    = 1'b0;
            period_d = 1'b1;
         end else if (!ctr_sh_q) begin
            dir_d = 1'b0;
            if (cnt_q >= top_sh_q) begin
               cnt_d    = '0;
               period_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end else if (!dir_q) begin
            if (cnt_q < top_sh_q) begin
               cnt_d = cnt_q + CNT_ONE;
            end else if (top_sh_q == CNT_ONE) begin
               // Down phase collapses into the peak tick when top is 1.
               cnt_d    = '0;
               period_d = 1'b1;
            end else begin
               dir_d = 1'b1;
               cnt_d = top_sh_q - CNT_ONE;
            end
         end else if (cnt_q > CNT_ONE) begin
            cnt_d = cnt_q - CNT_ONE;
         end else begin
            cnt_d    = '0;
            dir_d    = 1'b0;
            period_d = 1'b1;
         end
      end else begin
         pre_d = pre_q + PRE_ONE;
      end

      if (period_d) begin
         load_sh = 1'b1;
      end
   end

   assign pre_sh_d = load_sh ? prescale_i : pre_sh_q;
   assign top_sh_d = load_sh ? top_i      : top_sh_q;
   assign ctr_sh_d = load_sh ? center_i   : ctr_sh_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pre_q    <= '0;
         cnt_q    <= '0;
         dir_q    <= 1'b0;
         tick_q   <= 1'b0;
         period_q <= 1'b0;
         pre_sh_q <= '0;
         top_sh_q <= TOP_RST;
         ctr_sh_q <= 1'b0;
      end else begin
         pre_q    <= pre_d;
         cnt_q    <= cnt_d;
         dir_q    <= dir_d;
         tick_q   <= tick_d;
         period_q <= period_d;
         pre_sh_q <= pre_sh_d;
         top_sh_q <= top_sh_d;
         ctr_sh_q <= ctr_sh_d;
      end
   end

   assign counter_o = cnt_q;
   assign dir_o     = dir_q;
   assign tick_o    = tick_q;
   assign period_o  = period_q;

endmodule
